// File: rtl/alu_defs_pkg.sv
// Shared definitions for the EX-stage ALU with iterative multiply/divide.
// Contents: aluop encodings, 5-bit aluctl codes, the M-op func7 pattern,
// FSM state type and small helpers that classify M ops by signedness.
package alu_defs;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_I   = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_BR  = 2'b11;

  localparam logic [6:0] FUNC7_MD = 7'b0000001;

  // Bit 4 set marks an M op; the low three bits of an M op are its func3,
  // so bit 2 selects the divide group and bit 1 selects remainder.
  localparam logic [4:0] CTL_ADD    = 5'h00;
  localparam logic [4:0] CTL_SUB    = 5'h01;
  localparam logic [4:0] CTL_SLL    = 5'h02;
  localparam logic [4:0] CTL_SLT    = 5'h03;
  localparam logic [4:0] CTL_SLTU   = 5'h04;
  localparam logic [4:0] CTL_XOR    = 5'h05;
  localparam logic [4:0] CTL_SRL    = 5'h06;
  localparam logic [4:0] CTL_SRA    = 5'h07;
  localparam logic [4:0] CTL_OR     = 5'h08;
  localparam logic [4:0] CTL_AND    = 5'h09;
  localparam logic [4:0] CTL_MUL    = 5'h10;
  localparam logic [4:0] CTL_MULH   = 5'h11;
  localparam logic [4:0] CTL_MULHSU = 5'h12;
  localparam logic [4:0] CTL_MULHU  = 5'h13;
  localparam logic [4:0] CTL_DIV    = 5'h14;
  localparam logic [4:0] CTL_DIVU   = 5'h15;
  localparam logic [4:0] CTL_REM    = 5'h16;
  localparam logic [4:0] CTL_REMU   = 5'h17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  function automatic logic op_signed_a(input logic [4:0] ctl);
    return (ctl == CTL_MULH) || (ctl == CTL_MULHSU) ||
           (ctl == CTL_DIV)  || (ctl == CTL_REM);
  endfunction

  function automatic logic op_signed_b(input logic [4:0] ctl);
    return (ctl == CTL_MULH) || (ctl == CTL_DIV) || (ctl == CTL_REM);
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide datapath, one bit per cycle for XLEN cycles.
// Ports:
//   clk, rst       clock, synchronous active-high reset (aborts any run)
//   start          load operands and begin a run (op must be an M op)
//   op             aluctl code of the M op
//   src_a, src_b   operands, sampled on start
//   done           high during the last iteration cycle
//   result         final signed-corrected result; valid while done=1
// Multiply: shift-add on magnitudes into {acc_hi, acc_lo}.
// Divide:   restoring division on magnitudes; acc_hi = remainder,
//           acc_lo = dividend shifting out / quotient shifting in.
module alu_md_iter
  import alu_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);

  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   acc_hi, acc_lo, m_opnd;
  logic [4:0]        op_q;
  logic              neg_q, neg_r;

  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;

  logic [XLEN:0]     sum, rs;
  logic              ge;
  logic [XLEN-1:0]   diff, hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rmd;

  always_comb begin
    neg_a = op_signed_a(op) && src_a[XLEN-1];
    neg_b = op_signed_b(op) && src_b[XLEN-1];
    mag_a = neg_a ? -src_a : src_a;
    mag_b = neg_b ? -src_b : src_b;
  end

  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_opnd} : {(XLEN+1){1'b0}});
    rs   = {acc_hi, acc_lo[XLEN-1]};
    ge   = (rs >= {1'b0, m_opnd});
    // When ge the true difference is below m_opnd, so XLEN bits suffice.
    diff = rs[XLEN-1:0] - m_opnd;
    if (op_q[2]) begin
      hi_nx = ge ? diff : rs[XLEN-1:0];
      lo_nx = {acc_lo[XLEN-2:0], ge};
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

  // Result is formed from the next-state values so the top can register
  // it on the same edge as the final iteration.
  always_comb begin
    prod     = {hi_nx, lo_nx};
    prod_fix = neg_q ? -prod : prod;
    quo      = neg_q ? -lo_nx : lo_nx;
    rmd      = neg_r ? -hi_nx : hi_nx;
    case (op_q)
      CTL_MUL:                          result = prod_fix[XLEN-1:0];
      CTL_MULH, CTL_MULHSU, CTL_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      CTL_DIV, CTL_DIVU:                result = quo;
      default:                          result = rmd;
    endcase
  end

  assign done = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      m_opnd <= '0;
      op_q   <= CTL_MUL;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (start) begin
      cnt    <= CNT_INIT;
      acc_hi <= '0;
      acc_lo <= mag_a;
      m_opnd <= mag_b;
      op_q   <= op;
      neg_q  <= neg_a ^ neg_b;
      neg_r  <= neg_a;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      acc_hi <= hi_nx;
      acc_lo <= lo_nx;
    end
  end

endmodule

// File: rtl/alu_exec_md.sv
// EX-stage ALU: decodes aluop/func3/func7, executes single-cycle ops and
// fast M cases in one cycle, and hands other M ops to alu_md_iter.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake from ID/EX
//   aluop, func3, func7   decode inputs
//   src_a, src_b          operands (src_b may be an immediate)
//   out_valid / out_ready result handshake to EX/MEM
//   result, zero          registered result and result==0 flag
//   busy                  iterative M op in progress
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready for a new op (unless output is blocked)
// ST_CALC | alu_md_iter running; inputs ignored
module alu_exec_md
  import alu_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  state_t          state, state_nx;
  logic [4:0]      ctl;
  logic            is_md;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, imm_res, iter_res;
  logic            need_iter, iter_done;
  logic            a_zero, b_zero, b_ones, a_min, ovf;
  logic            accept, start_iter;

  always_comb begin
    is_md = (MD_EN != 0) && (aluop == ALUOP_R) && (func7 == FUNC7_MD);
    ctl   = CTL_ADD;
    case (aluop)
      ALUOP_I, ALUOP_R: begin
        if (is_md) begin
          ctl = {2'b10, func3};
        end else begin
          case (func3)
            3'b000:  ctl = (aluop == ALUOP_R && func7[5]) ? CTL_SUB : CTL_ADD;
            3'b001:  ctl = CTL_SLL;
            3'b010:  ctl = CTL_SLT;
            3'b011:  ctl = CTL_SLTU;
            3'b100:  ctl = CTL_XOR;
            3'b101:  ctl = func7[5] ? CTL_SRA : CTL_SRL;
            3'b110:  ctl = CTL_OR;
            default: ctl = CTL_AND;
          endcase
        end
      end
      ALUOP_BR: begin
        if (func3[2] & func3[1])      ctl = CTL_SLTU;
        else if (func3[2] ^ func3[1]) ctl = CTL_SLT;
        else                          ctl = CTL_SUB;
      end
      default: ctl = CTL_ADD;
    endcase
  end

  always_comb begin
    shamt = src_b[SHW-1:0];
    case (ctl)
      CTL_ADD:  alu_res = src_a + src_b;
      CTL_SUB:  alu_res = src_a - src_b;
      CTL_SLL:  alu_res = src_a << shamt;
      CTL_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      CTL_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      CTL_XOR:  alu_res = src_a ^ src_b;
      CTL_SRL:  alu_res = src_a >> shamt;
      CTL_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      CTL_OR:   alu_res = src_a | src_b;
      CTL_AND:  alu_res = src_a & src_b;
      default:  alu_res = '0;
    endcase
  end

  // M cases with a closed-form answer skip the iterative unit.
  always_comb begin
    a_zero    = (src_a == '0);
    b_zero    = (src_b == '0);
    b_ones    = &src_b;
    a_min     = (src_a == {1'b1, {(XLEN-1){1'b0}}});
    ovf       = a_min && b_ones;
    need_iter = 1'b0;
    imm_res   = alu_res;
    case (ctl)
      CTL_MUL, CTL_MULH, CTL_MULHSU, CTL_MULHU: begin
        imm_res   = '0;
        need_iter = !(a_zero || b_zero);
      end
      CTL_DIV: begin
        if (b_zero)   imm_res = '1;
        else if (ovf) imm_res = src_a;
        else          need_iter = 1'b1;
      end
      CTL_DIVU: begin
        if (b_zero) imm_res = '1;
        else        need_iter = 1'b1;
      end
      CTL_REM: begin
        if (b_zero)   imm_res = src_a;
        else if (ovf) imm_res = '0;
        else          need_iter = 1'b1;
      end
      CTL_REMU: begin
        if (b_zero) imm_res = src_a;
        else        need_iter = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready   = (state == ST_IDLE) && !(out_valid && !out_ready);
  assign accept     = in_valid && in_ready;
  assign start_iter = accept && need_iter;
  assign busy       = (state == ST_CALC);

  alu_md_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start_iter),
    .op     (ctl),
    .src_a  (src_a),
    .src_b  (src_b),
    .done   (iter_done),
    .result (iter_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_iter) state_nx = ST_CALC;
      ST_CALC: if (iter_done)  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !need_iter) begin
        out_valid <= 1'b1;
        result    <= imm_res;
        zero      <= (imm_res == '0);
      end else if (state == ST_CALC && iter_done) begin
        out_valid <= 1'b1;
        result    <= iter_res;
        zero      <= (iter_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_md.sv
`timescale 1ns/1ps
module tb_alu_exec_md;

  localparam int XLEN = 32;
  localparam int L1 = 1;
  localparam int LM = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      aluop = 2'b00;
  logic [2:0]      func3 = 3'b000;
  logic [6:0]      func7 = 7'b0;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  alu_exec_md #(.XLEN(XLEN), .MD_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .func3     (func3),
    .func7     (func7),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic held_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation each time a new result appears and checks
  // that a result held under backpressure does not change.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!held_prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=0x%08h required=none", result);
        end else begin
          cur = sb.pop_front();
          chk({cur.name, "_result"}, result, cur.res);
          chk({cur.name, "_zero"}, 32'(zero), 32'(cur.res == 32'h0));
          chk({cur.name, "_latency"}, 32'(cyc - cur.acc), 32'(cur.lat));
        end
      end else begin
        chk("held_result_stable", result, cur.res);
      end
    end
    held_prev = out_valid && !out_ready && !rst;
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input int lat, input string name);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    aluop = op;
    func3 = f3;
    func7 = f7;
    src_a = a;
    src_b = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept actual=in_ready_low required=accepted", name);
      in_valid = 1'b0;
    end else begin
      e.res  = r;
      e.lat  = lat;
      e.acc  = cyc;
      e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      aluop = 2'b10;
      func3 = 3'b111;
      func7 = 7'b0100000;
      src_a = 32'hA5A5_5A5A;
      src_b = 32'h1234_5678;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain actual=pending=%0d required=pending=0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Single-cycle ops
    issue(2'b10, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd12, L1, "r_add"); drain("r_add");
    issue(2'b10, 3'b000, 7'b0100000, 32'd7, 32'd7, 32'd0, L1, "r_sub"); drain("r_sub");
    issue(2'b01, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'hF800_0000, L1, "i_sra"); drain("i_sra");
    issue(2'b01, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4, 32'h0800_0000, L1, "i_srl"); drain("i_srl");
    issue(2'b01, 3'b101, 7'b0000000, 32'h8000_0000, 32'h24, 32'h0800_0000, L1, "i_srl_mask"); drain("i_srl_mask");
    issue(2'b11, 3'b110, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd1, L1, "br_sltu"); drain("br_sltu");
    issue(2'b11, 3'b100, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 32'd0, L1, "br_slt"); drain("br_slt");
    issue(2'b11, 3'b000, 7'b0000000, 32'd9, 32'd4, 32'd5, L1, "br_sub"); drain("br_sub");
    issue(2'b10, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd1, L1, "r_slt"); drain("r_slt");
    issue(2'b10, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd0, L1, "r_sltu"); drain("r_sltu");
    issue(2'b10, 3'b100, 7'b0000000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, L1, "r_xor"); drain("r_xor");
    issue(2'b10, 3'b110, 7'b0000000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, L1, "r_or"); drain("r_or");
    issue(2'b10, 3'b111, 7'b0000000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, L1, "r_and"); drain("r_and");
    issue(2'b10, 3'b001, 7'b0000000, 32'd1, 32'h21, 32'd2, L1, "r_sll_mask"); drain("r_sll_mask");
    issue(2'b00, 3'b100, 7'b0000001, 32'd3, 32'd4, 32'd7, L1, "mem_add"); drain("mem_add");
    issue(2'b01, 3'b000, 7'b0000001, 32'd10, 32'd20, 32'd30, L1, "i_add_f7"); drain("i_add_f7");

    // Iterative multiply; busy and in_ready checked through the whole run
    issue(2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, LM, "mul");
    for (int i = 0; i < XLEN; i++) begin
      @(negedge clk);
      chk("mul_calc_busy", 32'(busy), 32'h1);
      chk("mul_calc_in_ready", 32'(in_ready), 32'h0);
    end
    drain("mul");
    issue(2'b10, 3'b001, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LM, "mulh"); drain("mulh");
    issue(2'b10, 3'b011, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, LM, "mulhu"); drain("mulhu");
    issue(2'b10, 3'b010, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LM, "mulhsu"); drain("mulhsu");
    issue(2'b10, 3'b000, 7'b0000001, 32'd0, 32'd5, 32'd0, L1, "mul_zero"); drain("mul_zero");

    // Divide: fast cases and iterative cases
    issue(2'b10, 3'b100, 7'b0000001, 32'd7, 32'd0, 32'hFFFF_FFFF, L1, "div_by0"); drain("div_by0");
    issue(2'b10, 3'b110, 7'b0000001, 32'd7, 32'd0, 32'd7, L1, "rem_by0"); drain("rem_by0");
    issue(2'b10, 3'b100, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, L1, "div_ovf"); drain("div_ovf");
    issue(2'b10, 3'b110, 7'b0000001, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, L1, "rem_ovf"); drain("rem_ovf");
    issue(2'b10, 3'b100, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LM, "div_neg"); drain("div_neg");
    issue(2'b10, 3'b110, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LM, "rem_neg"); drain("rem_neg");
    issue(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd14, LM, "divu"); drain("divu");
    issue(2'b10, 3'b111, 7'b0000001, 32'd100, 32'd7, 32'd2, LM, "remu"); drain("remu");

    // Backpressure: result held for 5 cycles while out_ready is low
    out_ready = 1'b0;
    issue(2'b10, 3'b000, 7'b0000000, 32'd3, 32'd4, 32'd7, L1, "bp_add");
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    drain("bp_add");

    // Reset in the middle of an iterative op
    issue(2'b10, 3'b000, 7'b0000001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, LM, "mul_abort");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    repeat (40) @(negedge clk);
    issue(2'b10, 3'b000, 7'b0000000, 32'd20, 32'd22, 32'd42, L1, "post_rst_add"); drain("post_rst_add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
